// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 128-bit lines, four-beat refill.
// Supports abort of the in-flight response and a walking invalidate-all.
module icache_dm #(
    parameter int INDEX_W = 6,
    localparam int TAG_W = 32 - 4 - INDEX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  icache_pcin,
    input  logic         icache_ren,
    input  logic         icache_abort,
    output logic [127:0] icache_dout,
    output logic         icache_dout_valid,
    output logic         icache_busy,
    input  logic         inv_all,
    output logic         mem_ren,
    output logic [31:0]  mem_addr,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_rvalid
);

    localparam int NL = 2 ** INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESPOND,
        S_INVAL
    } state_t;

    state_t             state_q, state_d;
    logic [27:0]        req_line_q, req_line_d;
    logic [1:0]         beat_q, beat_d;
    logic               drop_q, drop_d;
    logic [INDEX_W:0]   cnt_q, cnt_d;
    logic [95:0]        lbuf_q, lbuf_d;
    logic [127:0]       dout_q, dout_d;
    logic               mem_ren_q, mem_ren_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [NL-1:0]      valid_q, valid_d;

    logic [TAG_W-1:0]   tag_mem  [NL];
    logic [127:0]       data_mem [NL];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill_we;
    logic [127:0]       fill_line;
    logic               unused_ok;

    assign idx = req_line_q[INDEX_W-1:0];
    assign tag = req_line_q[27:INDEX_W];
    assign hit = valid_q[idx] && (tag_mem[idx] == tag);
    assign fill_line = {mem_rdata, lbuf_q};
    assign unused_ok = &{1'b0, icache_pcin[3:0], cnt_q[INDEX_W]};

    assign icache_dout       = dout_q;
    assign icache_dout_valid = (state_q == S_RESPOND) && !icache_abort;
    assign icache_busy       = (state_q != S_IDLE);
    assign mem_ren           = mem_ren_q;
    assign mem_addr          = mem_addr_q;

    // Next-state and datapath updates for the request/refill/invalidate FSM
    always_comb begin
        state_d    = state_q;
        req_line_d = req_line_q;
        beat_d     = beat_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        lbuf_d     = lbuf_q;
        dout_d     = dout_q;
        mem_ren_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        fill_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (icache_abort) begin
                    state_d = S_IDLE;
                end else if (inv_all) begin
                    state_d = S_INVAL;
                    cnt_d   = '0;
                end else if (icache_ren) begin
                    req_line_d = icache_pcin[31:4];
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (icache_abort) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    dout_d  = data_mem[idx];
                    state_d = S_RESPOND;
                end else begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = {req_line_q, 4'b0};
                    beat_d     = 2'd0;
                    state_d    = S_REFILL;
                end
            end
            S_REFILL: begin
                if (icache_abort) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid) begin
                    beat_d = beat_q + 2'd1;
                    case (beat_q)
                        2'd0: lbuf_d[31:0]  = mem_rdata;
                        2'd1: lbuf_d[63:32] = mem_rdata;
                        2'd2: lbuf_d[95:64] = mem_rdata;
                        default: begin
                            fill_we      = 1'b1;
                            valid_d[idx] = 1'b1;
                            dout_d       = fill_line;
                            drop_d       = 1'b0;
                            state_d      = (drop_q || icache_abort)
                                         ? S_IDLE : S_RESPOND;
                        end
                    endcase
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            S_INVAL: begin
                valid_d[cnt_q[INDEX_W-1:0]] = 1'b0;
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q[INDEX_W-1:0]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, valid bits and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_line_q <= '0;
            beat_q     <= '0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            lbuf_q     <= '0;
            dout_q     <= '0;
            mem_ren_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_line_q <= req_line_d;
            beat_q     <= beat_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            lbuf_q     <= lbuf_d;
            dout_q     <= dout_d;
            mem_ren_q  <= mem_ren_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    // Tag/data arrays, written once per completed refill
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= fill_line;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomised scoreboard bench for icache_dm.
// Reference model: map of index -> cached line address plus a word memory.
module tb_icache_dm;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  icache_pcin = '0;
    logic         icache_ren = 1'b0;
    logic         icache_abort = 1'b0;
    logic [127:0] icache_dout;
    logic         icache_dout_valid;
    logic         icache_busy;
    logic         inv_all = 1'b0;
    logic         mem_ren;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rvalid = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_q[$];
    logic [31:0]  addr_q[$];
    logic [27:0]  mline [int];
    logic [31:0]  mem [logic [31:0]];

    always #5 clk = ~clk;

    icache_dm dut (
        .clk(clk),
        .reset(reset),
        .icache_pcin(icache_pcin),
        .icache_ren(icache_ren),
        .icache_abort(icache_abort),
        .icache_dout(icache_dout),
        .icache_dout_valid(icache_dout_valid),
        .icache_busy(icache_busy),
        .inv_all(inv_all),
        .mem_ren(mem_ren),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] line_of(input logic [27:0] ln);
        return {word({ln, 4'hC}), word({ln, 4'h8}),
                word({ln, 4'h4}), word({ln, 4'h0})};
    endfunction

    // Monitor: every response and refill request is matched to the model
    always @(negedge clk) begin
        if (!reset) begin
            if (icache_dout_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dout_valid", 1, 0);
                end else begin
                    check("dout", icache_dout, exp_q.pop_front());
                end
            end
            if (mem_ren) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_mem_ren", 1, 0);
                end else begin
                    check("mem_addr", {96'd0, mem_addr}, {96'd0, addr_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
    endtask

    // One request; ab_rf >= 0 aborts in the gap after that beat index
    task automatic do_req(input logic [31:0] a, input bit ab_lk,
                          input int ab_rf, input bit fixed);
        logic [27:0] ln;
        int          ix;
        bit          hit;
        int          gap;
        ln  = a[31:4];
        ix  = int'(a[9:4]);
        hit = mline.exists(ix) && (mline[ix] == ln);
        icache_ren  = 1'b1;
        icache_pcin = a;
        tick();
        icache_ren  = 1'b0;
        icache_pcin = $urandom;
        check("busy_lookup", {127'd0, icache_busy}, 1);
        if (ab_lk) begin
            icache_abort = 1'b1;
            tick();
            icache_abort = 1'b0;
            check("abort_lookup_idle", {127'd0, icache_busy}, 0);
        end else if (hit) begin
            exp_q.push_back(line_of(ln));
            tick();
            check("hit_valid", {126'd0, icache_dout_valid, icache_busy}, 3);
            check("hit_no_mem_ren", {127'd0, mem_ren}, 0);
            tick();
            check("hit_done", {126'd0, icache_dout_valid, icache_busy}, 0);
        end else begin
            addr_q.push_back({ln, 4'b0});
            tick();
            check("miss_mem_ren", {127'd0, mem_ren}, 1);
            for (int b = 0; b < 4; b++) begin
                gap = fixed ? ((b == 2) ? 1 : 0) : $urandom_range(0, 2);
                repeat (gap) tick();
                beat(word({ln, 2'(b), 2'b00}));
                if (b == ab_rf) begin
                    icache_abort = 1'b1;
                    tick();
                    icache_abort = 1'b0;
                end
            end
            mline[ix] = ln;
            if (ab_rf < 0) exp_q.push_back(line_of(ln));
            check("fill_valid", {127'd0, icache_dout_valid},
                  {127'd0, (ab_rf < 0)});
            tick();
            check("fill_done", {127'd0, icache_busy}, 0);
        end
        check("exp_q_drained", exp_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int n;
        mem[32'h1010] = 32'h11;
        mem[32'h1014] = 32'h22;
        mem[32'h1018] = 32'h33;
        mem[32'h101C] = 32'h44;
        #1;
        check("reset_outs",
              {icache_dout, 1'b0},
              {128'd0, icache_dout_valid | mem_ren | icache_busy});
        check("reset_mem_addr", {96'd0, mem_addr}, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Cold miss with the known line contents
        do_req(32'h0000_1010, 0, -1, 1);
        check("cold_line", icache_dout,
              128'h00000044_00000033_00000022_00000011);
        // Hit on another word of the same line
        do_req(32'h0000_101C, 0, -1, 0);
        // Conflict eviction and re-miss
        do_req(32'h0000_1410, 0, -1, 0);
        do_req(32'h0000_1010, 0, -1, 0);
        // Abort in lookup on a hit, then abort during refill
        do_req(32'h0000_1010, 1, -1, 0);
        do_req(32'h0000_2020, 0, 0, 0);
        do_req(32'h0000_2020, 0, -1, 0);

        // Invalidate-all wins over a simultaneous request
        inv_all     = 1'b1;
        icache_ren  = 1'b1;
        icache_pcin = 32'h0000_1010;
        tick();
        inv_all    = 1'b0;
        icache_ren = 1'b0;
        n = 0;
        while (icache_busy && n < 200) begin
            tick();
            n++;
        end
        check("inval_cycles", n, 64);
        mline.delete();
        do_req(32'h0000_1010, 0, -1, 0);

        // Reset in the middle of a refill
        a = 32'h0000_3330;
        addr_q.push_back(a);
        icache_ren  = 1'b1;
        icache_pcin = a;
        tick();
        icache_ren = 1'b0;
        tick();
        beat(word(a));
        beat(word(a + 4));
        reset = 1'b1;
        #1;
        check("rst_mid_outs",
              {icache_dout[126:0], icache_dout_valid},
              {127'd0, mem_ren | icache_busy | icache_dout[127]});
        check("rst_mid_addr", {96'd0, mem_addr}, 0);
        tick();
        reset = 1'b0;
        beat(word(a + 8));
        beat(word(a + 12));
        check("rst_beats_ignored", {127'd0, icache_busy}, 0);
        tick();
        do_req(a, 0, -1, 0);

        // Randomised traffic over a few conflicting tags and indices
        for (int i = 0; i < 60; i++) begin
            a = (32'($urandom_range(1, 3)) << 10)
              | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
            do_req(a,
                   ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1,
                   0);
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
